// File: rtl/tdc_tsfifo.sv
// Timestamp buffer behind the TDC core. Each channel has a one-entry pending
// register. The lowest-index pending entry moves into a shared FIFO, and the
// CPU drains that FIFO over Wishbone. Each FIFO entry is two 32-bit words.
module tdc_tsfifo #(
    parameter int unsigned g_CHANNEL_COUNT = 2,
    parameter int unsigned g_TS_WIDTH      = 38,
    parameter int unsigned g_DEPTH_LOG2    = 5
) (
    input  logic                                  wb_clk_i,
    input  logic                                  rst_n_i,
    input  logic [2:0]                            wb_addr_i,
    input  logic [31:0]                           wb_data_i,
    output logic [31:0]                           wb_data_o,
    input  logic                                  wb_cyc_i,
    input  logic                                  wb_stb_i,
    input  logic                                  wb_we_i,
    input  logic [3:0]                            wb_sel_i,
    output logic                                  wb_ack_o,
    output logic                                  wb_irq_o,
    input  logic [g_CHANNEL_COUNT-1:0]            detect_i,
    input  logic [g_CHANNEL_COUNT-1:0]            polarity_i,
    input  logic [g_CHANNEL_COUNT*g_TS_WIDTH-1:0] timestamp_i
);
    localparam int unsigned c_DEPTH = 2 ** g_DEPTH_LOG2;
    localparam logic [g_DEPTH_LOG2:0] c_FULL_LEVEL = {1'b1, {g_DEPTH_LOG2{1'b0}}};

    // Per-channel pending entries, held already formatted as FIFO words
    logic [g_CHANNEL_COUNT-1:0] r_pend_valid;
    logic [31:0]                r_pend_lo [g_CHANNEL_COUNT];
    logic [31:0]                r_pend_hi [g_CHANNEL_COUNT];

    // FIFO storage and bookkeeping
    logic [31:0]             r_mem_lo [c_DEPTH];
    logic [31:0]             r_mem_hi [c_DEPTH];
    logic [g_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [g_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [g_DEPTH_LOG2:0]   r_level;

    // Control / status state
    logic        r_ctrl_en;
    logic        r_ctrl_irq_en;
    logic        r_ovf;
    logic [15:0] r_drops;

    // Bus-side registers
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_irq;

    logic                       w_req;
    logic                       w_rd;
    logic                       w_wr;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_pend_any;
    logic [6:0]                 w_sel_ch;
    logic [31:0]                w_sel_lo;
    logic [31:0]                w_sel_hi;
    logic [g_CHANNEL_COUNT-1:0] w_drop_vec;
    logic [7:0]                 w_drop_n;
    logic [16:0]                w_drop_sum;
    logic [31:0]                w_rd_data;
    logic                       w_unused;

    // Byte selects are ignored (full-word access only); unused data bits are sunk here
    assign w_unused = ^{wb_sel_i, wb_data_i[31:19], wb_data_i[17:2]};

    // A new access is accepted only while ack is low, so each access takes two cycles
    assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_rd    = w_req & ~wb_we_i;
    assign w_wr    = w_req & wb_we_i;
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL_LEVEL);
    // DATA_HI read pops the head on the same edge that raises ack
    assign w_pop   = w_rd & (wb_addr_i == 3'd2) & ~w_empty;
    assign w_push  = w_pend_any & (~w_full | w_pop);

    // Pick the lowest-index pending channel and count this cycle's dropped events
    always_comb begin
        w_pend_any = 1'b0;
        w_sel_ch   = '0;
        w_sel_lo   = '0;
        w_sel_hi   = '0;
        for (int n = int'(g_CHANNEL_COUNT) - 1; n >= 0; n--) begin
            if (r_pend_valid[n]) begin
                w_pend_any = 1'b1;
                w_sel_ch   = 7'(n);
                w_sel_lo   = r_pend_lo[n];
                w_sel_hi   = r_pend_hi[n];
            end
        end
        w_drop_vec = detect_i & r_pend_valid & {g_CHANNEL_COUNT{r_ctrl_en}};
        w_drop_n   = '0;
        for (int n = 0; n < int'(g_CHANNEL_COUNT); n++) begin
            w_drop_n = w_drop_n + 8'(w_drop_vec[n]);
        end
        w_drop_sum = {1'b0, r_drops} + 17'(w_drop_n);
    end

    // Latch new events into empty pending slots; clear the slot that moves into the FIFO
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend_valid <= '0;
            for (int n = 0; n < int'(g_CHANNEL_COUNT); n++) begin
                r_pend_lo[n] <= '0;
                r_pend_hi[n] <= '0;
            end
        end else begin
            for (int n = 0; n < int'(g_CHANNEL_COUNT); n++) begin
                if (r_ctrl_en && detect_i[n] && !r_pend_valid[n]) begin
                    r_pend_valid[n] <= 1'b1;
                    r_pend_lo[n]    <= timestamp_i[n*g_TS_WIDTH +: 32];
                    r_pend_hi[n]    <= {polarity_i[n], 7'(n),
                                        24'(timestamp_i[n*g_TS_WIDTH+32 +: g_TS_WIDTH-32])};
                end else if (w_push && (w_sel_ch == 7'(n))) begin
                    r_pend_valid[n] <= 1'b0;
                end
            end
        end
    end

    // FIFO storage write (contents are not reset)
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem_lo[r_wr_ptr] <= w_sel_lo;
            r_mem_hi[r_wr_ptr] <= w_sel_hi;
        end
    end

    // FIFO pointers and level; a push and a pop together leave the level unchanged
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // CONTROL, overflow flag and saturating drop counter; a new drop beats a clear
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctrl_en     <= 1'b0;
            r_ctrl_irq_en <= 1'b0;
            r_ovf         <= 1'b0;
            r_drops       <= '0;
        end else begin
            if (w_wr && (wb_addr_i == 3'd3)) begin
                r_ctrl_en     <= wb_data_i[0];
                r_ctrl_irq_en <= wb_data_i[1];
            end
            if (|w_drop_vec) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (wb_addr_i == 3'd0) && wb_data_i[18]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (wb_addr_i == 3'd4)) begin
                r_drops <= 16'(w_drop_n);
            end else if (w_drop_sum[16]) begin
                r_drops <= 16'hFFFF;
            end else begin
                r_drops <= w_drop_sum[15:0];
            end
        end
    end

    // Register read mux; an empty FIFO reads as zero
    always_comb begin
        w_rd_data = '0;
        case (wb_addr_i)
            3'd0: w_rd_data = {13'd0, r_ovf, w_full, w_empty, 16'(r_level)};
            3'd1: if (!w_empty) w_rd_data = r_mem_lo[r_rd_ptr];
            3'd2: if (!w_empty) w_rd_data = r_mem_hi[r_rd_ptr];
            3'd3: w_rd_data = {30'd0, r_ctrl_irq_en, r_ctrl_en};
            3'd4: w_rd_data = {16'd0, r_drops};
            default: w_rd_data = '0;
        endcase
    end

    // Registered ack, read data and level interrupt
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rd_data : '0;
            r_irq <= r_ctrl_irq_en & ~w_empty;
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_data_o = r_dat;
    assign wb_irq_o  = r_irq;

endmodule

// File: tb/tb_tdc_tsfifo.sv
// Self-checking bench for tdc_tsfifo: register table, directed corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_tdc_tsfifo;
    localparam int C     = 2;
    localparam int W     = 38;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    wb_addr = '0;
    logic [31:0]   wb_wdat = '0;
    logic [31:0]   wb_rdat;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'hF;
    logic          ack, irq;
    logic [C-1:0]  detect = '0, pol = '0;
    logic [C*W-1:0] ts = '0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    tdc_tsfifo #(
        .g_CHANNEL_COUNT(C),
        .g_TS_WIDTH     (W),
        .g_DEPTH_LOG2   (5)
    ) dut (
        .wb_clk_i   (clk),
        .rst_n_i    (rst_n),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_wdat),
        .wb_data_o  (wb_rdat),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_sel_i   (sel),
        .wb_ack_o   (ack),
        .wb_irq_o   (irq),
        .detect_i   (detect),
        .polarity_i (pol),
        .timestamp_i(ts)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone access, started at a negedge; returns at the negedge after ack
    task automatic wb_acc(input logic [2:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic irq_at);
        logic got;
        got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; wb_addr = a; wb_wdat = d;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        rd = wb_rdat;
        irq_at = irq;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        logic        i;
        wb_acc(a, 1'b0, 32'd0, v, i);
        chk(name, v, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] v;
        logic        i;
        wb_acc(a, 1'b1, d, v, i);
    endtask

    // One-cycle detect pulse plus one idle cycle; called at a negedge
    task automatic pulse(input logic [1:0] det, input logic [1:0] p,
                         input logic [W-1:0] t0, input logic [W-1:0] t1);
        detect = det; pol = p; ts = {t1, t0};
        @(negedge clk);
        detect = '0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Detect on ch0 two cycles running, the second coincident with a register write
    task automatic drop_with_write(input logic [2:0] a, input logic [31:0] d,
                                   input logic [W-1:0] t0, input logic [W-1:0] t1);
        detect = 2'b01; pol = 2'b00; ts = {38'd0, t0};
        @(negedge clk);
        ts = {38'd0, t1};
        cyc = 1'b1; stb = 1'b1; we = 1'b1; wb_addr = a; wb_wdat = d;
        @(posedge clk); #1;
        detect = '0;
        chk("dww_ack", {31'd0, ack}, 32'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    // Register-access table
    typedef struct {
        logic [2:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[13];

    // Reference model state
    logic [63:0] m_q[$];
    logic        m_pv[C];
    logic [63:0] m_pe[C];
    logic        m_ovf;
    int          m_drops;
    logic        m_irq;
    logic [31:0] m_rdat;

    // Advance the model by one clock edge given the inputs in force before it
    task automatic model_step(input logic req, input logic [2:0] a, input logic [C-1:0] det,
                              input logic [C-1:0] p, input logic [C*W-1:0] tsv);
        int          lvl;
        logic [63:0] head;
        logic        pv_pre[C];
        logic        done;
        lvl  = m_q.size();
        head = (lvl > 0) ? m_q[0] : 64'd0;
        if (req) begin
            case (a)
                3'd0:    m_rdat = {13'd0, m_ovf, lvl == DEPTH, lvl == 0, 16'(lvl)};
                3'd1:    m_rdat = head[31:0];
                3'd2:    m_rdat = head[63:32];
                3'd3:    m_rdat = 32'd3;
                3'd4:    m_rdat = 32'(m_drops);
                default: m_rdat = 32'd0;
            endcase
        end
        m_irq = (lvl != 0);
        if (req && a == 3'd2 && lvl > 0) void'(m_q.pop_front());
        for (int n = 0; n < C; n++) pv_pre[n] = m_pv[n];
        done = 1'b0;
        for (int n = 0; n < C; n++) begin
            if (m_pv[n] && !done) begin
                done = 1'b1;
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(m_pe[n]);
                    m_pv[n] = 1'b0;
                end
            end
        end
        for (int n = 0; n < C; n++) begin
            if (det[n]) begin
                if (pv_pre[n]) begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end else begin
                    m_pv[n] = 1'b1;
                    m_pe[n] = {p[n], 7'(n), 24'(tsv[n*W+32 +: W-32]), tsv[n*W +: 32]};
                end
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        irq_at;
        int          rise;
        logic        prev_req;
        logic        prev_rd;
        logic        req;
        logic [2:0]  a;
        int          rate;
        int          pick;

        do_reset();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_data", wb_rdat, 32'd0);

        // Register table: reset values, undefined addresses, CONTROL read/write
        tbl[0]  = '{3'd0, 1'b0, 32'd0,         32'h0001_0000};
        tbl[1]  = '{3'd3, 1'b0, 32'd0,         32'd0};
        tbl[2]  = '{3'd4, 1'b0, 32'd0,         32'd0};
        tbl[3]  = '{3'd1, 1'b0, 32'd0,         32'd0};
        tbl[4]  = '{3'd2, 1'b0, 32'd0,         32'd0};
        tbl[5]  = '{3'd5, 1'b0, 32'd0,         32'd0};
        tbl[6]  = '{3'd3, 1'b1, 32'hFFFF_FFFF, 32'd0};
        tbl[7]  = '{3'd3, 1'b0, 32'd0,         32'd3};
        tbl[8]  = '{3'd3, 1'b1, 32'd2,         32'd0};
        tbl[9]  = '{3'd3, 1'b0, 32'd0,         32'd2};
        tbl[10] = '{3'd7, 1'b0, 32'd0,         32'd0};
        tbl[11] = '{3'd3, 1'b1, 32'd0,         32'd0};
        tbl[12] = '{3'd0, 1'b0, 32'd0,         32'h0001_0000};
        for (int i = 0; i < 13; i++) begin
            wb_acc(tbl[i].a, tbl[i].w, tbl[i].d, v, irq_at);
            if (!tbl[i].w) chk($sformatf("tbl%0d", i), v, tbl[i].exp);
        end

        // 1: single event on ch0
        wr(3'd3, 32'd1);
        pulse(2'b01, 2'b01, 38'h2A_1234_5678, 38'd0);
        rd_chk("t1_status", 3'd0, 32'h0000_0001);
        rd_chk("t1_lo", 3'd1, 32'h1234_5678);
        rd_chk("t1_hi", 3'd2, 32'h8000_002A);
        rd_chk("t1_empty", 3'd0, 32'h0001_0000);

        // 2: simultaneous events serialise lowest channel first
        pulse(2'b11, 2'b00, 38'd5, 38'd9);
        @(negedge clk);
        rd_chk("t2_status", 3'd0, 32'h0000_0002);
        rd_chk("t2_lo0", 3'd1, 32'd5);
        rd_chk("t2_hi0", 3'd2, 32'h0000_0000);
        rd_chk("t2_lo1", 3'd1, 32'd9);
        rd_chk("t2_hi1", 3'd2, 32'h0100_0000);
        rd_chk("t2_empty", 3'd0, 32'h0001_0000);

        // 3: fill, one held in pending, one dropped, pop lets pending in
        for (int i = 0; i < DEPTH; i++) pulse(2'b01, 2'b01, 38'(i), 38'd0);
        pulse(2'b01, 2'b01, 38'd100, 38'd0);
        pulse(2'b01, 2'b01, 38'd200, 38'd0);
        rd_chk("t3_full", 3'd0, 32'h0006_0020);
        rd_chk("t3_drops", 3'd4, 32'd1);
        rd_chk("t3_lo0", 3'd1, 32'd0);
        rd_chk("t3_hi0", 3'd2, 32'h8000_0000);
        rd_chk("t3_full_after_pop", 3'd0, 32'h0006_0020);
        for (int i = 1; i < DEPTH; i++) begin
            rd_chk($sformatf("t3_lo%0d", i), 3'd1, 32'(i));
            rd_chk($sformatf("t3_hi%0d", i), 3'd2, 32'h8000_0000);
        end
        rd_chk("t3_lo_pend", 3'd1, 32'd100);
        rd_chk("t3_hi_pend", 3'd2, 32'h8000_0000);
        rd_chk("t3_drained", 3'd0, 32'h0005_0000);
        wr(3'd0, 32'h0004_0000);
        rd_chk("t3_ovf_clr", 3'd0, 32'h0001_0000);
        wr(3'd4, 32'd0);
        rd_chk("t3_drops_clr", 3'd4, 32'd0);

        // 4: interrupt rise and fall
        wr(3'd3, 32'd3);
        detect = 2'b10; pol = 2'b00; ts = {38'd7, 38'd0};
        rise = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            detect = '0;
            if (irq && rise == 0) rise = k;
        end
        chk("t4_irq_rise", {31'd0, (rise >= 1 && rise <= 3)}, 32'd1);
        @(negedge clk);
        wb_acc(3'd2, 1'b0, 32'd0, v, irq_at);
        chk("t4_hi", v, 32'h0100_0000);
        chk("t4_irq_at_pop", {31'd0, irq_at}, 32'd1);
        @(posedge clk); #1;
        chk("t4_irq_fall", {31'd0, irq}, 32'd0);
        @(negedge clk);

        // 5: reset in the middle of an access with entries queued
        for (int i = 0; i < 5; i++) pulse(2'b01, 2'b00, 38'(10 + i), 38'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; wb_addr = 3'd0;
        @(posedge clk); #1;
        chk("t5_ack_pre", {31'd0, ack}, 32'd1);
        chk("t5_irq_pre", {31'd0, irq}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ack_rst", {31'd0, ack}, 32'd0);
        chk("t5_irq_rst", {31'd0, irq}, 32'd0);
        chk("t5_data_rst", wb_rdat, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("t5_status", 3'd0, 32'h0001_0000);
        rd_chk("t5_ctrl", 3'd3, 32'd0);

        // 6: disabled capture, then coincident drop with W1C and DROPS clear
        for (int i = 0; i < 3; i++) pulse(2'b11, 2'b11, 38'd1, 38'd2);
        detect = 2'b11; @(negedge clk); detect = '0; @(negedge clk);
        rd_chk("t6_dis_status", 3'd0, 32'h0001_0000);
        rd_chk("t6_dis_drops", 3'd4, 32'd0);
        wr(3'd3, 32'd1);
        detect = 2'b01; pol = 2'b00; ts = {38'd0, 38'd20};
        @(negedge clk);
        ts = {38'd0, 38'd21};
        @(negedge clk);
        detect = '0;
        @(negedge clk); @(negedge clk);
        rd_chk("t6_first_drop", 3'd0, 32'h0004_0001);
        rd_chk("t6_drops1", 3'd4, 32'd1);
        drop_with_write(3'd0, 32'h0004_0000, 38'd22, 38'd23);
        rd_chk("t6_ovf_sticky", 3'd0, 32'h0004_0002);
        rd_chk("t6_drops2", 3'd4, 32'd2);
        drop_with_write(3'd4, 32'd0, 38'd24, 38'd25);
        rd_chk("t6_drops_one", 3'd4, 32'd1);
        rd_chk("t6_status3", 3'd0, 32'h0004_0003);

        // Randomized traffic against the reference model
        do_reset();
        wr(3'd3, 32'd3);
        m_q.delete();
        for (int n = 0; n < C; n++) begin
            m_pv[n] = 1'b0;
            m_pe[n] = '0;
        end
        m_ovf    = 1'b0;
        m_drops  = 0;
        m_irq    = 1'b0;
        m_rdat   = '0;
        prev_req = 1'b1;  // ack of the CONTROL write is still high here
        prev_rd  = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            chk("rnd_ack", {31'd0, ack}, {31'd0, prev_req});
            chk("rnd_irq", {31'd0, irq}, {31'd0, m_irq});
            if (prev_req && prev_rd) chk("rnd_rdata", wb_rdat, m_rdat);
            rate = (t < 1000) ? 45 : 8;
            for (int n = 0; n < C; n++) begin
                detect[n] = ($urandom_range(0, 99) < rate);
                pol[n]    = $urandom_range(0, 1) == 1;
            end
            ts  = (C*W)'({$urandom(), $urandom(), $urandom()});
            req = !prev_req && ($urandom_range(0, 99) < 70);
            pick = $urandom_range(0, 19);
            a = (pick < 10) ? 3'd2 : (pick < 15) ? 3'd0 : (pick < 18) ? 3'd1 : 3'd4;
            cyc = req; stb = req; we = 1'b0; wb_addr = a;
            model_step(req, a, detect, pol, ts);
            prev_req = req;
            prev_rd  = req;
            @(posedge clk);
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0; detect = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
